// File: rtl/bist_pattern_compactor.sv
// Exhaustive pattern driver and SISR response compactor
// for N-input, 1-output combinational benchmark circuits.
module bist_pattern_compactor #(
  parameter int              N_IN  = 4,
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter int              LAT   = 0
) (
  input  logic              CK,
  input  logic              RESET,
  input  logic              start,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic [N_IN-1:0]   pattern,
  output logic              pattern_valid,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN:0]     ones_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [N_IN-1:0] PLAST = '1;
  localparam logic [2:0] DLAST =
    (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  logic [1:0]       state;
  logic [2:0]       dcnt;
  logic             samp;
  logic             go;
  logic [SIG_W-1:0] sig_nxt;
  logic [N_IN:0]    ones_nxt;

  // Delay pattern_valid by LAT edges to mark response edges
  generate
    if (LAT == 0) begin : g_nopipe
      assign samp = pattern_valid;
    end else begin : g_pipe
      logic [LAT:1] vp;
      always_ff @(posedge CK or posedge RESET) begin
        if (RESET) vp <= '0;
        else       vp <= LAT'({vp, pattern_valid});
      end
      assign samp = vp[LAT];
    end
  endgenerate

  assign go   = start &&
                (state == S_IDLE || state == S_DONE);
  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // Next SISR value and ones count for a sample edge
  always_comb begin
    sig_nxt  = signature;
    ones_nxt = ones_count;
    if (samp) begin
      sig_nxt = {signature[SIG_W-2:0], 1'b0} ^
                (signature[SIG_W-1] ? POLY : '0);
      sig_nxt[0] = sig_nxt[0] ^ resp;
      ones_nxt = ones_count + {{N_IN{1'b0}}, resp};
    end
  end

  // Run control, pattern counter and result registers
  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      dcnt          <= '0;
      pattern       <= '0;
      pattern_valid <= 1'b0;
      pass          <= 1'b0;
      signature     <= '0;
      ones_count    <= '0;
    end else if (go) begin
      state         <= S_RUN;
      dcnt          <= '0;
      pattern       <= '0;
      pattern_valid <= 1'b1;
      pass          <= 1'b0;
      signature     <= '0;
      ones_count    <= '0;
    end else begin
      signature  <= sig_nxt;
      ones_count <= ones_nxt;
      unique case (state)
        S_RUN: begin
          if (pattern == PLAST) begin
            pattern_valid <= 1'b0;
            dcnt          <= '0;
            if (LAT > 0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_DONE;
              pass  <= (sig_nxt == expected_sig);
            end
          end else begin
            pattern <= pattern + 1'b1;
          end
        end
        S_DRAIN: begin
          if (dcnt == DLAST) begin
            state <= S_DONE;
            pass  <= (sig_nxt == expected_sig);
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_compactor.sv
// Scoreboard bench for bist_pattern_compactor,
// one instance combinational (LAT=0), one with LAT=2.
module tb_bist_pattern_compactor;

  localparam int NP = 16;

  typedef struct packed {
    logic [15:0] sig;
    logic [4:0]  ones;
    logic        pass;
  } exp_t;

  logic        CK = 1'b0;
  logic        RESET;
  logic        start0, start2;
  logic [15:0] esig;
  int          mode;
  int          lsel;

  logic [3:0]  pat0, pat2;
  logic        pv0, pv2, busy0, busy2;
  logic        done0, done2, pass0, pass2;
  logic [15:0] sig0, sig2;
  logic [4:0]  ones0, ones2;
  logic        resp0, resp2, d1, d2;

  logic [3:0]  o_pat;
  logic        o_pv, o_busy, o_done, o_pass;
  logic [15:0] o_sig;
  logic [4:0]  o_ones;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 CK = ~CK;

  function automatic logic fcut(input int m,
                                input logic [3:0] p);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return p[0];
      default: return p[3];
    endcase
  endfunction

  assign resp0 = fcut(mode, pat0);

  always_ff @(posedge CK) begin
    d1 <= fcut(mode, pat2);
    d2 <= d1;
  end
  assign resp2 = d2;

  bist_pattern_compactor #(.LAT(0)) dut0 (
    .CK(CK), .RESET(RESET), .start(start0),
    .expected_sig(esig), .pattern(pat0),
    .pattern_valid(pv0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0),
    .signature(sig0), .ones_count(ones0)
  );

  bist_pattern_compactor #(.LAT(2)) dut2 (
    .CK(CK), .RESET(RESET), .start(start2),
    .expected_sig(esig), .pattern(pat2),
    .pattern_valid(pv2), .resp(resp2),
    .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2), .ones_count(ones2)
  );

  always_comb begin
    if (lsel == 2) begin
      o_pat = pat2; o_pv = pv2; o_busy = busy2;
      o_done = done2; o_pass = pass2;
      o_sig = sig2; o_ones = ones2;
    end else begin
      o_pat = pat0; o_pv = pv0; o_busy = busy0;
      o_done = done0; o_pass = pass0;
      o_sig = sig0; o_ones = ones0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int m,
                                 input logic [15:0] e);
    exp_t r;
    logic [15:0] s;
    logic msb, b;
    int n;
    s = '0;
    n = 0;
    for (int k = 0; k < NP; k++) begin
      b   = fcut(m, 4'(k));
      msb = s[15];
      s   = {s[14:0], 1'b0};
      if (msb) s = s ^ 16'h1021;
      s[0] = s[0] ^ b;
      if (b) n++;
    end
    r.sig  = s;
    r.ones = 5'(n);
    r.pass = (s == e);
    return r;
  endfunction

  task automatic set_start(input logic v);
    if (lsel == 2) start2 = v;
    else           start0 = v;
  endtask

  task automatic kick();
    @(negedge CK);
    set_start(1'b1);
    @(posedge CK);
    #1;
  endtask

  task automatic finish_run(input int lat,
                            input int poke,
                            input bit hold);
    int   cyc;
    int   bc;
    exp_t e;
    cyc = 0;
    bc  = 0;
    while (!o_done && cyc < 100) begin
      if (o_busy) bc++;
      if (cyc < NP) begin
        chk("pattern", o_pat, cyc);
        chk("pattern_valid", o_pv, 1);
      end
      if (!hold) set_start(cyc == poke);
      @(posedge CK);
      #1;
      cyc++;
    end
    if (!hold) set_start(1'b0);
    chk("latency", cyc, NP + lat);
    chk("busy_cycles", bc, NP + lat);
    chk("pv_drop", o_pv, 0);
    chk("pat_hold", o_pat, NP - 1);
    chk("busy_end", o_busy, 0);
    chk("done", o_done, 1);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("signature", o_sig, e.sig);
      chk("ones_count", o_ones, e.ones);
      chk("pass", o_pass, e.pass);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pattern"}, o_pat, 0);
    chk({tag, "_pv"}, o_pv, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_sig"}, o_sig, 0);
    chk({tag, "_ones"}, o_ones, 0);
  endtask

  initial begin
    exp_t e;
    RESET  = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    esig   = '0;
    mode   = 0;
    lsel   = 0;

    @(posedge CK);
    #1;
    chk_zero("rst0");
    lsel = 2;
    #0;
    chk_zero("rst2");
    @(negedge CK);
    RESET = 1'b0;

    // all-ones response
    lsel = 0; mode = 0; esig = 16'hFFFF;
    sb.push_back('{16'hFFFF, 5'd16, 1'b1});
    kick();
    finish_run(0, -1, 1'b0);

    // all-zeros response, mismatching golden value
    mode = 1; esig = 16'h0001;
    sb.push_back('{16'h0000, 5'd0, 1'b0});
    kick();
    finish_run(0, -1, 1'b0);

    // identity on first input
    mode = 2;
    e = model(2, 16'h0);
    esig = e.sig;
    sb.push_back(model(2, esig));
    chk("model_ones_id", e.ones, 8);
    kick();
    finish_run(0, -1, 1'b0);

    // two-cycle CUT latency, resp = pattern[3]
    lsel = 2; mode = 3;
    e = model(3, 16'h0);
    esig = e.sig;
    sb.push_back(model(3, esig));
    kick();
    finish_run(2, -1, 1'b0);

    // asynchronous abort at cycle 7
    lsel = 0; mode = 3;
    kick();
    set_start(1'b0);
    repeat (7) @(posedge CK);
    #2;
    RESET = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge CK);
    RESET = 1'b0;
    @(posedge CK);
    #1;
    chk("idle_busy", o_busy, 0);
    chk("idle_pv", o_pv, 0);
    sb.push_back(model(3, esig));
    kick();
    finish_run(0, -1, 1'b0);

    // start pulse in the middle of a run is ignored
    sb.push_back(model(3, esig));
    kick();
    finish_run(0, 5, 1'b0);

    // start held high: restart on DONE entry
    mode = 2;
    e = model(2, 16'h0);
    esig = e.sig;
    sb.push_back(model(2, esig));
    kick();
    finish_run(0, -1, 1'b1);
    sb.push_back(model(2, esig));
    @(posedge CK);
    #1;
    chk("restart_sig", o_sig, 0);
    chk("restart_ones", o_ones, 0);
    chk("restart_busy", o_busy, 1);
    chk("restart_done", o_done, 0);
    chk("restart_pass", o_pass, 0);
    set_start(1'b0);
    finish_run(0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
